// File: rtl/eth_pcs_tx_scrambler_if.sv
// Encoder-to-scrambler block handshake: one 66-bit block (payload + sync header) per valid/ready transfer.
// master = encoder side, slave = scrambler side.
interface eth_pcs_tx_scrambler_if #(
  parameter int W_BLK  = 64,
  parameter int W_SYNC = 2
);
  logic              blk_valid;
  logic [W_BLK-1:0]  blk_data;
  logic [W_SYNC-1:0] blk_sync;
  logic              blk_ready;

  modport master (output blk_valid, blk_data, blk_sync, input blk_ready);
  modport slave  (input blk_valid, blk_data, blk_sync, output blk_ready);
endinterface

// File: rtl/eth_pcs_tx_scrambler.sv
// TX PCS x^58+x^39+1 scrambler feeding the gearbox one chunk per enabled cycle; idle block inserted on underflow.
// Accepted block shows at next chunk 0; ready only at the last enabled chunk. ETH_PCS_TX_SCR_BYPASS_EN adds i_scr_bypass.
module eth_pcs_tx_scrambler #(
  parameter int          W_DATA          = 32,
  parameter int          W_SYNC          = 2,
  parameter int          W_BLK           = 64,
  parameter int          W_TRANS_PER_BLK = 1,
  parameter logic [57:0] SCR_SEED        = 58'h3FF_FFFF_FFFF_FFFF
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  eth_pcs_tx_scrambler_if.slave      blk_if,
`ifdef ETH_PCS_TX_SCR_BYPASS_EN
  input  logic                       i_scr_bypass,
`endif
  input  logic                       i_clk_en,
  input  logic [W_TRANS_PER_BLK-1:0] i_trans_cnt,
  output logic [W_DATA-1:0]          o_scr_data,
  output logic [W_SYNC-1:0]          o_sync_data,
  output logic                       o_lblock,
  output logic [15:0]                o_underflow_cnt
);
  localparam int TRANS_PER_BLK = W_BLK / W_DATA;
  localparam logic [W_TRANS_PER_BLK-1:0] LAST_TRANS = W_TRANS_PER_BLK'(TRANS_PER_BLK - 1);
  localparam logic [W_BLK-1:0]  LBLOCK_DATA = W_BLK'(8'h1E);
  localparam logic [W_SYNC-1:0] LBLOCK_SYNC = W_SYNC'(2'b01);

  logic [W_BLK-1:0]           q_blk;
  logic [W_SYNC-1:0]          q_sync;
  logic [57:0]                q_scr;
  logic [15:0]                q_underflow_cnt;
  logic [W_TRANS_PER_BLK-1:0] trans_idx;
  logic [W_DATA-1:0]          chunk;
  logic [W_DATA-1:0]          scr_chunk;
  logic [57:0]                scr_hist;
  logic                       blk_ready;
  logic                       scr_bypass;

`ifdef ETH_PCS_TX_SCR_BYPASS_EN
  assign scr_bypass = i_scr_bypass;
`else
  assign scr_bypass = 1'b0;
`endif

  // Out-of-range transfer indices behave as the last chunk of the block.
  assign trans_idx = (int'(i_trans_cnt) >= TRANS_PER_BLK) ? LAST_TRANS : i_trans_cnt;
  assign chunk     = q_blk[int'(trans_idx)*W_DATA +: W_DATA];

  // scr_hist[0] is the latest scrambled bit, so taps 39/58 sit at [38]/[57].
  always_comb begin
    scr_hist  = q_scr;
    scr_chunk = '0;
    for (int j = 0; j < W_DATA; j++) begin
      scr_chunk[j] = chunk[j] ^ scr_hist[38] ^ scr_hist[57];
      scr_hist     = {scr_hist[56:0], scr_chunk[j]};
    end
  end

  assign blk_ready        = i_clk_en && (trans_idx == LAST_TRANS) && !i_reset;
  assign blk_if.blk_ready = blk_ready;
  assign o_lblock         = blk_ready && !blk_if.blk_valid;
  assign o_scr_data       = scr_bypass ? chunk : scr_chunk;
  assign o_sync_data      = q_sync;
  assign o_underflow_cnt  = q_underflow_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      q_scr           <= SCR_SEED;
      q_blk           <= LBLOCK_DATA;
      q_sync          <= LBLOCK_SYNC;
      q_underflow_cnt <= '0;
    end else begin
      if (i_clk_en && !scr_bypass) begin
        q_scr <= scr_hist;
      end
      if (blk_ready) begin
        if (blk_if.blk_valid) begin
          q_blk  <= blk_if.blk_data;
          q_sync <= blk_if.blk_sync;
        end else begin
          q_blk  <= LBLOCK_DATA;
          q_sync <= LBLOCK_SYNC;
          if (q_underflow_cnt != 16'hFFFF) begin
            q_underflow_cnt <= q_underflow_cnt + 16'd1;
          end
        end
      end
    end
  end
endmodule

// File: doc/eth_pcs_tx_scrambler.md
Name: eth_pcs_tx_scrambler

Overview:
TX PCS stage directly upstream of the TX gearbox. Accepts whole 66-bit blocks (64-bit payload plus 2-bit sync header) from the encoder over a valid/ready handshake and holds each block. Presents the block to the gearbox one W_DATA chunk per enabled cycle, scrambled with the self-synchronous polynomial x^58 + x^39 + 1. When the encoder has no block at a block boundary, it inserts an idle control block (LBLOCK_T).

Parameters:
W_DATA, 32, width of one transfer chunk to the gearbox
W_SYNC, 2, sync header width
W_BLK, 64, block payload width; TRANS_PER_BLK = W_BLK/W_DATA (2)
W_TRANS_PER_BLK, 1, width of transfer index = clog2(TRANS_PER_BLK)
SCR_SEED, 58'h3FF_FFFF_FFFF_FFFF, scrambler state after reset

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_blk_valid  in  1  encoder block available
i_blk_data  in  W_BLK  block payload, bit 0 transmitted first
i_blk_sync  in  W_SYNC  block sync header
o_blk_ready  out  1  block accepted this cycle when i_blk_valid=1
i_clk_en  in  1  gearbox clock enable (gearbox o_clk_en)
i_trans_cnt  in  W_TRANS_PER_BLK  gearbox transfer index (gearbox o_trans_cnt)
o_scr_data  out  W_DATA  scrambled chunk, to gearbox i_scr_data
o_sync_data  out  W_SYNC  sync header of held block, to gearbox i_sync_data
o_lblock  out  1  one-cycle pulse: idle block inserted
o_underflow_cnt  out  16  saturating count of inserted idle blocks

Behaviour:
- Holding register q_blk/q_sync holds the block currently being sent; scrambler state q_scr holds 58 bits, with q_scr[0] being the most recently transmitted scrambled bit.
- Chunk select is combinational: chunk = q_blk[i_trans_cnt*W_DATA +: W_DATA].
- o_scr_data is combinational from q_scr and chunk only. There is no path from i_blk_* to the outputs.
- Scrambling is bitwise in transmit order, j = 0..W_DATA-1: s_j = d_j ^ p(39) ^ p(58). p(n) is the scrambled bit transmitted n bit times earlier, drawn from q_scr or from earlier bits of the same chunk.
- o_sync_data = q_sync. The sync header is never scrambled.
- On i_clk_en=1, q_scr updates to the 58 most recent scrambled bits. On i_clk_en=0, q_scr, q_blk and q_sync all hold.
- o_blk_ready = i_clk_en && (i_trans_cnt == TRANS_PER_BLK-1). This is combinational, and a transfer occurs when o_blk_ready && i_blk_valid.
- At a block boundary (o_blk_ready=1) the holding register loads as follows:
  - if i_blk_valid=1: q_blk <= i_blk_data, q_sync <= i_blk_sync;
  - else (LBLOCK_T): q_blk <= {56'h0, 8'h1E}, q_sync <= 2'b01 (control header, bit0=1 sent first); o_lblock pulses in the same cycle; o_underflow_cnt increments and saturates at 16'hFFFF.
- Latency: a block accepted in cycle N appears on the outputs, starting with chunk 0, at the next enabled cycle with i_trans_cnt=0.
- Reset: q_scr=SCR_SEED; q_blk/q_sync = LBLOCK_T; o_underflow_cnt=0; o_lblock=0.
- Reset mid-block: the partial block is dropped, and the next chunk 0 after reset is LBLOCK_T. The encoder sees no ready during reset.
- i_trans_cnt out of range (>= TRANS_PER_BLK): treated as TRANS_PER_BLK-1.
- i_blk_valid may drop without being accepted; the encoder holds its data until ready.

Optional Feature:
ETH_PCS_TX_SCR_BYPASS_EN adds an input port i_scr_bypass (1 bit).
- With the macro defined and i_scr_bypass=1: o_scr_data = chunk, unscrambled, and q_scr holds. This is used for PMA test patterns.
- Without the macro: the port is absent and scrambling is always active.

Test Plan:
- Reset, i_blk_valid=0, i_clk_en=1 toggling trans_cnt 0,1 -> first chunk carries o_sync_data=2'b01; o_lblock pulses at each trans_cnt=1; o_underflow_cnt counts 1,2,3.
- SCR_SEED=0, send block 64'h1 then 64'h0 -> o_scr_data = 32'h0000_0001, then 32'h0400_0080, then 32'h0000_4000.
- SCR_SEED=0, all-zero blocks with sync 2'b10 -> o_scr_data always 0; o_sync_data=2'b10 at every trans_cnt=0.
- i_clk_en=0 for one cycle mid-block -> o_scr_data and o_sync_data unchanged that cycle; o_blk_ready=0; sequence resumes identically afterwards.
- Random blocks versus a reference LFSR model -> all chunks match; a software descrambler recovers the payloads; i_reset asserted mid-block -> the next chunk-0 block after reset is LBLOCK_T.
- Force 65540 idle insertions -> o_underflow_cnt saturates at 16'hFFFF.
